iec_listener: RTL

Device-side endpoint of the IEC serial bus that the computer drives through `serial_atn`, `serial_clock_o` and `serial_data_o`. The block receives bytes as a bus listener, with ATN command bytes and EOI detection, and holds off the talker until the consumer takes each byte. It is the first piece of a disk-drive/peripheral model attached to the serial connector, and is simulated back-to-back with the computer model. Talker mode and turnaround are not supported.

---
 rtl/iec_pkg.sv | 33 +++
 rtl/iec_sync.sv | 32 +++
 rtl/iec_listener.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iec_pkg.sv
// IEC serial bus shared definitions: endpoint FSM states, command bytes
// and bus timings in microseconds.
package iec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_READY,
        ST_EOI_ACK,
        ST_EOI_WAIT,
        ST_BIT_LO,
        ST_BIT_HI,
        ST_FRAME
    } iec_state_t;

    localparam logic [7:0] CMD_LISTEN    = 8'h20;
    localparam logic [7:0] CMD_UNLISTEN  = 8'h3F;
    localparam logic [7:0] CMD_TALK      = 8'h40;
    localparam logic [7:0] CMD_UNTALK    = 8'h5F;
    localparam logic [7:0] CMD_SECONDARY = 8'h60;

    localparam int unsigned T_EOI     = 200;
    localparam int unsigned T_EOI_ACK = 60;
    localparam int unsigned T_BIT_TO  = 1000;

    function automatic logic [31:0] us_to_cycles(
        input int unsigned us,
        input int unsigned clk_per_us
    );
        return 32'(us * clk_per_us);
    endfunction

endpackage

// File: rtl/iec_sync.sv
// Two-flop synchronizer for an open-collector bus line, with single-cycle
// rise/fall pulses derived from the synchronized level.
module iec_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], din};
    end

    // Lines idle released, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/iec_listener.sv
// IEC serial bus listener endpoint: receives ATN command and data bytes,
// acknowledges EOI, and holds DATA low until the consumer takes each byte.
module iec_listener
    import iec_pkg::*;
#(
    parameter int unsigned DEVICE_ADDR = 8,
    parameter int unsigned CLK_PER_US  = 8
) (
    input  logic       dot_clk,
    input  logic       reset,
    input  logic       serial_atn,
    input  logic       serial_clock_i,
    input  logic       serial_data_i,
    output logic       serial_clock_o,
    output logic       serial_data_o,
    output logic [7:0] rx_data,
    output logic       rx_atn,
    output logic       rx_eoi,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       listening,
    output logic       frame_err
);

    localparam logic [7:0]  ADDR       = 8'(DEVICE_ADDR);
    localparam logic [31:0] EOI_CYC    = us_to_cycles(T_EOI, CLK_PER_US);
    localparam logic [31:0] EOI_ACK_CYC = us_to_cycles(T_EOI_ACK, CLK_PER_US);
    localparam logic [31:0] BIT_TO_CYC = us_to_cycles(T_BIT_TO, CLK_PER_US);

    logic atn_s, atn_rise, atn_fall;
    logic clk_s, clk_rise, clk_fall;
    logic dat_s, unused_dat_rise, unused_dat_fall;

    iec_sync u_sync_atn (
        .clk   (dot_clk),
        .rst   (reset),
        .din   (serial_atn),
        .level (atn_s),
        .rise  (atn_rise),
        .fall  (atn_fall)
    );

    iec_sync u_sync_clk (
        .clk   (dot_clk),
        .rst   (reset),
        .din   (serial_clock_i),
        .level (clk_s),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    iec_sync u_sync_dat (
        .clk   (dot_clk),
        .rst   (reset),
        .din   (serial_data_i),
        .level (dat_s),
        .rise  (unused_dat_rise),
        .fall  (unused_dat_fall)
    );

    iec_state_t  state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        eoi_q, eoi_d;
    logic        atn_mode_q, atn_mode_d;
    logic        listening_q, listening_d;
    logic        data_o_q, data_o_d;
    logic        frame_err_q, frame_err_d;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_atn_q, rx_atn_d;
    logic        rx_eoi_q, rx_eoi_d;

    logic eoi_hit, eoi_ack_done, bit_timeout;

    assign eoi_hit      = {16'd0, timer_q} >= EOI_CYC;
    assign eoi_ack_done = {16'd0, timer_q} >= EOI_ACK_CYC;
    assign bit_timeout  = {16'd0, timer_q} >= BIT_TO_CYC;

    always_comb begin
        state_d     = state_q;
        timer_d     = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        eoi_d       = eoi_q;
        atn_mode_d  = atn_mode_q;
        listening_d = listening_q;
        data_o_d    = data_o_q;
        frame_err_d = 1'b0;
        rx_valid_d  = rx_valid_q;
        rx_data_d   = rx_data_q;
        rx_atn_d    = rx_atn_q;
        rx_eoi_d    = rx_eoi_q;

        if (atn_fall) begin
            state_d    = ST_WAIT_RDY;
            data_o_d   = 1'b0;
            shreg_d    = 8'd0;
            bit_cnt_d  = 4'd0;
            eoi_d      = 1'b0;
            atn_mode_d = 1'b1;
            rx_valid_d = 1'b0;
        end else if (atn_rise) begin
            atn_mode_d = 1'b0;
            if (!listening_q) begin
                state_d    = ST_IDLE;
                data_o_d   = 1'b1;
                rx_valid_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    data_o_d = 1'b1;
                    if ((!atn_s || listening_q) && !clk_s) begin
                        state_d  = ST_WAIT_RDY;
                        data_o_d = 1'b0;
                    end
                end
                ST_WAIT_RDY: begin
                    if (clk_s) begin
                        state_d  = ST_READY;
                        data_o_d = 1'b1;
                    end
                end
                ST_READY: begin
                    if (clk_fall) begin
                        state_d   = ST_BIT_LO;
                        bit_cnt_d = 4'd0;
                    end else if (eoi_hit) begin
                        state_d  = ST_EOI_ACK;
                        eoi_d    = 1'b1;
                        data_o_d = 1'b0;
                    end
                end
                ST_EOI_ACK: begin
                    if (eoi_ack_done) begin
                        state_d  = ST_EOI_WAIT;
                        data_o_d = 1'b1;
                    end
                end
                ST_EOI_WAIT: begin
                    if (clk_fall) begin
                        state_d   = ST_BIT_LO;
                        bit_cnt_d = 4'd0;
                    end
                end
                ST_BIT_LO: begin
                    if (clk_rise) begin
                        state_d   = ST_BIT_HI;
                        shreg_d   = {dat_s, shreg_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (bit_timeout) begin
                        state_d     = ST_IDLE;
                        frame_err_d = 1'b1;
                        data_o_d    = 1'b1;
                        shreg_d     = 8'd0;
                        bit_cnt_d   = 4'd0;
                        eoi_d       = 1'b0;
                    end
                end
                ST_BIT_HI: begin
                    if (clk_fall && bit_cnt_q == 4'd8) begin
                        // Commands are decoded as the byte completes.
                        if (atn_mode_q) begin
                            if (shreg_q == (CMD_LISTEN | ADDR)) begin
                                listening_d = 1'b1;
                            end else if (shreg_q == CMD_UNLISTEN ||
                                         shreg_q == (CMD_TALK | ADDR)) begin
                                listening_d = 1'b0;
                            end
                        end
                        if (atn_mode_q || listening_q) begin
                            state_d    = ST_FRAME;
                            data_o_d   = 1'b0;
                            rx_valid_d = 1'b1;
                            rx_data_d  = shreg_q;
                            rx_atn_d   = atn_mode_q;
                            rx_eoi_d   = eoi_q & ~atn_mode_q;
                        end else begin
                            state_d  = ST_IDLE;
                            data_o_d = 1'b1;
                        end
                    end else if (clk_fall) begin
                        state_d = ST_BIT_LO;
                    end else if (bit_timeout) begin
                        state_d     = ST_IDLE;
                        frame_err_d = 1'b1;
                        data_o_d    = 1'b1;
                        shreg_d     = 8'd0;
                        bit_cnt_d   = 4'd0;
                        eoi_d       = 1'b0;
                    end
                end
                ST_FRAME: begin
                    data_o_d = 1'b0;
                    if (rx_valid_q && rx_ready) begin
                        state_d    = ST_WAIT_RDY;
                        rx_valid_d = 1'b0;
                        shreg_d    = 8'd0;
                        bit_cnt_d  = 4'd0;
                        eoi_d      = 1'b0;
                    end
                end
            endcase
        end

        if (state_d != state_q) begin
            timer_d = 16'd0;
        end
    end

    always_ff @(posedge dot_clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= 16'd0;
            shreg_q     <= 8'd0;
            bit_cnt_q   <= 4'd0;
            eoi_q       <= 1'b0;
            atn_mode_q  <= 1'b0;
            listening_q <= 1'b0;
            data_o_q    <= 1'b1;
            frame_err_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= 8'd0;
            rx_atn_q    <= 1'b0;
            rx_eoi_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            eoi_q       <= eoi_d;
            atn_mode_q  <= atn_mode_d;
            listening_q <= listening_d;
            data_o_q    <= data_o_d;
            frame_err_q <= frame_err_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            rx_atn_q    <= rx_atn_d;
            rx_eoi_q    <= rx_eoi_d;
        end
    end

    assign serial_clock_o = 1'b1;
    assign serial_data_o  = data_o_q;
    assign rx_data        = rx_data_q;
    assign rx_atn         = rx_atn_q;
    assign rx_eoi         = rx_eoi_q;
    assign rx_valid       = rx_valid_q;
    assign listening      = listening_q;
    assign frame_err      = frame_err_q;

endmodule
